// File: rtl/counter_pkg.sv
// Shared types and constants for the display counter.
// Latency: n/a (package only).
// Backpressure: n/a; the count source never stalls.
package counter_pkg;

  localparam int COUNT_W = 14;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // One count step with wrap in both directions, kept at COUNT_W bits.
  function automatic logic [COUNT_W-1:0] next_count(
    input logic [COUNT_W-1:0] cur,
    input logic               mode,
    input logic [COUNT_W-1:0] max_cnt
  );
    logic [COUNT_W-1:0] res;
    if (mode == MODE_UP) begin
      res = (cur == max_cnt) ? '0 : cur + COUNT_W'(1);
    end else begin
      res = (cur == '0) ? max_cnt : cur - COUNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Divide-by-DIV strobe generator, running only while enabled.
// Latency: strobe is high in the cycle the divider reads DIV-1 (DIV cycles after enable).
// Backpressure: none; dropping i_en clears the divider so the next period is a full one.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int              DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Free-running 0..DIV-1 counter, held at zero whenever disabled.
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign o_tick = i_en && (div_cnt == LAST);

endmodule

// File: rtl/counter_10000_ctrl.sv
// Run/stop/clear controlled up/down counter feeding the 4-digit display (0..MAX_COUNT).
// Latency: requests act on the next edge (one more with COUNTER_BTN_EDGE_EN); outputs registered.
// Backpressure: none; COUNTER_BTN_EDGE_EN turns held button levels into single requests.
module counter_10000_ctrl
  import counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 10,
  parameter int MAX_COUNT   = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_run_stop,
  input  logic               i_clear,
  input  logic               i_mode,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_tick,
  output logic               o_running
);

  localparam int                 DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  state_t             state;
  state_t             state_nxt;
  logic               run_req;
  logic               clr_req;
  logic               tick_stb;
  logic [COUNT_W-1:0] count_nxt;
  logic               tick_nxt;

`ifdef COUNTER_BTN_EDGE_EN
  logic run_q;
  logic run_q2;
  logic clr_q;
  logic clr_q2;
  logic primed;

  // Register the button levels and keep the previous sample for edge detection.
  // On the first cycle out of reset the history is loaded with the live level, so
  // a button already held through reset does not fire a request.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 1'b0;
      run_q2 <= 1'b0;
      clr_q  <= 1'b0;
      clr_q2 <= 1'b0;
      primed <= 1'b0;
    end else begin
      primed <= 1'b1;
      run_q  <= i_run_stop;
      clr_q  <= i_clear;
      run_q2 <= primed ? run_q : i_run_stop;
      clr_q2 <= primed ? clr_q : i_clear;
    end
  end

  assign run_req = run_q & ~run_q2;
  assign clr_req = clr_q & ~clr_q2;
`else
  assign run_req = i_run_stop;
  assign clr_req = i_clear;
`endif

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (state == ST_RUN),
    .o_tick (tick_stb)
  );

  // Next-state logic: clear beats run/stop, CLEAR always falls back to STOP.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: begin
        if (clr_req)      state_nxt = ST_CLEAR;
        else if (run_req) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clr_req)      state_nxt = ST_CLEAR;
        else if (run_req) state_nxt = ST_STOP;
      end
      ST_CLEAR: state_nxt = ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
  end

  // Count update: zero while leaving CLEAR, step on a strobe unless a clear coincides.
  always_comb begin
    count_nxt = o_count;
    tick_nxt  = 1'b0;
    if (state == ST_CLEAR) begin
      count_nxt = '0;
    end else if (tick_stb && !clr_req) begin
      count_nxt = next_count(o_count, i_mode, MAX_C);
      tick_nxt  = 1'b1;
    end
  end

  // State and output registers; o_running tracks the registered state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_STOP;
      o_count   <= '0;
      o_tick    <= 1'b0;
      o_running <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_count   <= count_nxt;
      o_tick    <= tick_nxt;
      o_running <= (state_nxt == ST_RUN);
    end
  end

endmodule
